// File: rtl/fib_pkg.sv
// Shared encodings for the longest-prefix-match FIB: update opcodes,
// update status codes and the scan controller states.
package fib_pkg;

    localparam logic OP_INSERT = 1'b0;
    localparam logic OP_DELETE = 1'b1;

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_REPLACED = 2'b01,
        ST_FULL     = 2'b10,
        ST_MISS     = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        FIN  = 2'b10
    } state_e;

endpackage

// File: rtl/fib_prefix_mask.sv
// Converts a prefix length into a mask of that many leading (MSB-side) ones.
// Lengths at or above PREFIX_W saturate to an all-ones mask.
module fib_prefix_mask #(
    parameter int PREFIX_W = 64,
    parameter int LEN_W    = $clog2(PREFIX_W + 1)
) (
    input  logic [LEN_W-1:0]    len,
    output logic [PREFIX_W-1:0] mask
);

    assign mask = ~({PREFIX_W{1'b1}} >> len);

endmodule

// File: rtl/fib_lpm.sv
// Register-based FIB with longest-prefix-match lookup. One insert, delete or
// lookup at a time, resolved by a DEPTH-cycle sequential scan of the table.
module fib_lpm #(
    parameter int PREFIX_W     = 64,
    parameter int LEN_W        = $clog2(PREFIX_W + 1),
    parameter int DEPTH        = 8,
    parameter int FACE_W       = 4,
    parameter int DEFAULT_FACE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                upd_valid,
    output logic                upd_ready,
    input  logic                upd_op,
    input  logic [PREFIX_W-1:0] upd_prefix,
    input  logic [LEN_W-1:0]    upd_len,
    input  logic [FACE_W-1:0]   upd_face,
    output logic                upd_done,
    output logic [1:0]          upd_status,
    input  logic                lk_valid,
    output logic                lk_ready,
    input  logic [PREFIX_W-1:0] lk_prefix,
    output logic                lk_done,
    output logic                lk_hit,
    output logic [LEN_W-1:0]    lk_len,
    output logic [FACE_W-1:0]   lk_face,
    output logic [LEN_W:0]      count
);
    import fib_pkg::*;

    localparam int                IDX_W    = $clog2(DEPTH);
    localparam int                CNT_W    = LEN_W + 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(PREFIX_W);
    localparam logic [FACE_W-1:0] DEF_FACE = FACE_W'(DEFAULT_FACE);

    logic [DEPTH-1:0]    tbl_valid;
    logic [LEN_W-1:0]    tbl_len    [DEPTH];
    logic [PREFIX_W-1:0] tbl_prefix [DEPTH];
    logic [FACE_W-1:0]   tbl_face   [DEPTH];

    state_e state, state_nxt;
    logic [IDX_W-1:0]    idx;
    logic                req_upd;
    logic                req_op;
    logic [PREFIX_W-1:0] req_key;
    logic [LEN_W-1:0]    req_len;
    logic [FACE_W-1:0]   req_face;

    // Scan accumulators: exact {len,prefix} match, first free slot, best LPM.
    logic ex_hit, fr_hit, bs_hit;
    logic [IDX_W-1:0] ex_idx, fr_idx;
    logic [LEN_W-1:0] bs_len;
    logic [FACE_W-1:0] bs_face;
    logic ex_hit_n, fr_hit_n, bs_hit_n;
    logic [IDX_W-1:0] ex_idx_n, fr_idx_n;
    logic [LEN_W-1:0] bs_len_n;
    logic [FACE_W-1:0] bs_face_n;

    logic             wr_en, wr_valid;
    logic [IDX_W-1:0] wr_idx;

    logic upd_acc, lk_acc, start, last;
    logic [PREFIX_W-1:0] key_mask, ent_mask;
    logic exact_now, match_now;
    status_e res_status;
    logic res_wr, res_valid;
    logic [IDX_W-1:0] res_idx;

    // NOTE: readies are gated by rst directly so they read 0 while reset is held
    // and 1 in the first cycle after it is released.
    assign upd_ready = (state == IDLE) && rst;
    assign lk_ready  = (state == IDLE) && rst && !upd_valid;
    assign upd_acc   = upd_valid && upd_ready;
    assign lk_acc    = lk_valid && lk_ready;
    assign start     = upd_acc || lk_acc;
    assign last      = (state == SCAN) && (idx == LAST_IDX);

    fib_prefix_mask #(.PREFIX_W(PREFIX_W), .LEN_W(LEN_W)) u_key_mask (
        .len  (upd_len),
        .mask (key_mask)
    );

    fib_prefix_mask #(.PREFIX_W(PREFIX_W), .LEN_W(LEN_W)) u_ent_mask (
        .len  (tbl_len[idx]),
        .mask (ent_mask)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (idx == LAST_IDX) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        exact_now = tbl_valid[idx] && (tbl_len[idx] == req_len) && (tbl_prefix[idx] == req_key);
        match_now = tbl_valid[idx] && ((req_key & ent_mask) == tbl_prefix[idx]);

        ex_hit_n  = ex_hit || exact_now;
        ex_idx_n  = ex_hit ? ex_idx : idx;
        fr_hit_n  = fr_hit || !tbl_valid[idx];
        fr_idx_n  = fr_hit ? fr_idx : idx;
        bs_hit_n  = bs_hit;
        bs_len_n  = bs_len;
        bs_face_n = bs_face;
        if (match_now && (!bs_hit || tbl_len[idx] > bs_len)) begin
            bs_hit_n  = 1'b1;
            bs_len_n  = tbl_len[idx];
            bs_face_n = tbl_face[idx];
        end
    end

    always_comb begin
        res_status = ST_MISS;
        res_wr     = 1'b0;
        res_valid  = 1'b0;
        res_idx    = ex_idx_n;
        if (req_op == OP_INSERT) begin
            if (req_len > MAX_LEN) begin
                res_status = ST_MISS;
            end else if (ex_hit_n) begin
                res_status = ST_REPLACED;
                res_wr     = 1'b1;
                res_valid  = 1'b1;
            end else if (fr_hit_n) begin
                res_status = ST_OK;
                res_wr     = 1'b1;
                res_valid  = 1'b1;
                res_idx    = fr_idx_n;
            end else begin
                res_status = ST_FULL;
            end
        end else if (ex_hit_n) begin
            res_status = ST_OK;
            res_wr     = 1'b1;
        end
    end

    // NOTE: table payload and request registers carry no reset; only the valid
    // bits, count and outputs are architectural after reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            req_upd  <= upd_acc;
            req_op   <= upd_op;
            req_key  <= upd_acc ? (upd_prefix & key_mask) : lk_prefix;
            req_len  <= upd_len;
            req_face <= upd_face;
            idx      <= '0;
            ex_hit   <= 1'b0;
            ex_idx   <= '0;
            fr_hit   <= 1'b0;
            fr_idx   <= '0;
            bs_hit   <= 1'b0;
            bs_len   <= '0;
            bs_face  <= '0;
        end
        if (state == SCAN) begin
            idx     <= idx + IDX_W'(1);
            ex_hit  <= ex_hit_n;
            ex_idx  <= ex_idx_n;
            fr_hit  <= fr_hit_n;
            fr_idx  <= fr_idx_n;
            bs_hit  <= bs_hit_n;
            bs_len  <= bs_len_n;
            bs_face <= bs_face_n;
            if (last) begin
                wr_en    <= req_upd && res_wr;
                wr_valid <= res_valid;
                wr_idx   <= res_idx;
            end
        end
        if (state == FIN && wr_en) begin
            tbl_len[wr_idx]    <= req_len;
            tbl_prefix[wr_idx] <= req_key;
            tbl_face[wr_idx]   <= req_face;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tbl_valid  <= '0;
            count      <= '0;
            upd_done   <= 1'b0;
            upd_status <= 2'b00;
            lk_done    <= 1'b0;
            lk_hit     <= 1'b0;
            lk_len     <= '0;
            lk_face    <= '0;
        end else begin
            upd_done <= last && req_upd;
            lk_done  <= last && !req_upd;
            if (last && req_upd) upd_status <= res_status;
            if (last && !req_upd) begin
                lk_hit  <= bs_hit_n;
                lk_len  <= bs_hit_n ? bs_len_n : '0;
                lk_face <= bs_hit_n ? bs_face_n : DEF_FACE;
            end
            if (state == FIN && wr_en) begin
                tbl_valid[wr_idx] <= wr_valid;
                if (wr_valid && !tbl_valid[wr_idx]) count <= count + CNT_W'(1);
                else if (!wr_valid)                 count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fib_lpm.sv
// Scoreboard bench for fib_lpm: stimulus pushes hand-computed expectations,
// a monitor pops and compares them whenever a done pulse appears.
module tb_fib_lpm;
    import fib_pkg::*;

    localparam int PREFIX_W = 64;
    localparam int LEN_W    = 7;
    localparam int DEPTH    = 8;
    localparam int FACE_W   = 4;
    localparam int LAT      = DEPTH + 1;

    logic                clk;
    logic                rst;
    logic                upd_valid, upd_ready, upd_op, upd_done;
    logic [PREFIX_W-1:0] upd_prefix;
    logic [LEN_W-1:0]    upd_len;
    logic [FACE_W-1:0]   upd_face;
    logic [1:0]          upd_status;
    logic                lk_valid, lk_ready, lk_done, lk_hit;
    logic [PREFIX_W-1:0] lk_prefix;
    logic [LEN_W-1:0]    lk_len;
    logic [FACE_W-1:0]   lk_face;
    logic [LEN_W:0]      count;

    fib_lpm #(
        .PREFIX_W(PREFIX_W), .LEN_W(LEN_W), .DEPTH(DEPTH),
        .FACE_W(FACE_W), .DEFAULT_FACE(15)
    ) dut (
        .clk(clk), .rst(rst),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_op(upd_op),
        .upd_prefix(upd_prefix), .upd_len(upd_len), .upd_face(upd_face),
        .upd_done(upd_done), .upd_status(upd_status),
        .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_prefix(lk_prefix),
        .lk_done(lk_done), .lk_hit(lk_hit), .lk_len(lk_len), .lk_face(lk_face),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_pass   = 0;
    int tag_n    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    typedef struct {
        logic [1:0] status;
        int         cnt;
        int         acc;
        int         tag;
    } upd_exp_t;

    typedef struct {
        logic              hit;
        logic [LEN_W-1:0]  len;
        logic [FACE_W-1:0] face;
        int                acc;
        int                tag;
    } lk_exp_t;

    upd_exp_t upd_q[$];
    lk_exp_t  lk_q[$];
    upd_exp_t ue;
    lk_exp_t  le;
    logic     cnt_pend = 1'b0;
    int       cnt_exp;
    int       cnt_tag;

    // Monitor: count settles one cycle after the update's done pulse.
    always @(negedge clk) begin
        if (cnt_pend) begin
            check($sformatf("upd%0d count", cnt_tag), 64'(count), 64'(cnt_exp));
            cnt_pend = 1'b0;
        end
        if (upd_done) begin
            if (upd_q.size() == 0) begin
                fail_now("unexpected upd_done");
            end else begin
                ue = upd_q.pop_front();
                check($sformatf("upd%0d status", ue.tag), 64'(upd_status), 64'(ue.status));
                check($sformatf("upd%0d latency", ue.tag), 64'(cyc - ue.acc), 64'(LAT));
                cnt_pend = 1'b1;
                cnt_exp  = ue.cnt;
                cnt_tag  = ue.tag;
            end
        end
        if (lk_done) begin
            if (lk_q.size() == 0) begin
                fail_now("unexpected lk_done");
            end else begin
                le = lk_q.pop_front();
                check($sformatf("lk%0d hit", le.tag), 64'(lk_hit), 64'(le.hit));
                check($sformatf("lk%0d len", le.tag), 64'(lk_len), 64'(le.len));
                check($sformatf("lk%0d face", le.tag), 64'(lk_face), 64'(le.face));
                check($sformatf("lk%0d latency", le.tag), 64'(cyc - le.acc), 64'(LAT));
            end
        end
    end

    task automatic wait_done();
        int i;
        for (i = 0; i < 40; i++) begin
            @(negedge clk);
            #2;
            if (upd_q.size() == 0 && lk_q.size() == 0 && !cnt_pend) break;
        end
        if (i == 40) fail_now("timeout waiting for done");
    endtask

    task automatic do_upd(input logic op, input logic [63:0] pfx, input int len, input int face,
                          input logic [1:0] st, input int cnt);
        upd_exp_t e;
        bit ok = 1'b0;
        @(negedge clk);
        upd_valid  = 1'b1;
        upd_op     = op;
        upd_prefix = pfx;
        upd_len    = LEN_W'(len);
        upd_face   = FACE_W'(face);
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if (upd_ready) begin
                ok = 1'b1;
                e.status = st; e.cnt = cnt; e.acc = cyc; e.tag = tag_n++;
                upd_q.push_back(e);
            end else begin
                @(negedge clk);
            end
        end
        @(posedge clk);
        #1 upd_valid = 1'b0;
        if (!ok) fail_now("timeout waiting for upd_ready");
        wait_done();
    endtask

    task automatic do_lk(input logic [63:0] pfx, input logic hit, input int len, input int face);
        lk_exp_t e;
        bit ok = 1'b0;
        @(negedge clk);
        lk_valid  = 1'b1;
        lk_prefix = pfx;
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if (lk_ready) begin
                ok = 1'b1;
                e.hit = hit; e.len = LEN_W'(len); e.face = FACE_W'(face); e.acc = cyc; e.tag = tag_n++;
                lk_q.push_back(e);
            end else begin
                @(negedge clk);
            end
        end
        @(posedge clk);
        #1 lk_valid = 1'b0;
        if (!ok) fail_now("timeout waiting for lk_ready");
        wait_done();
    endtask

    localparam logic [63:0] K_DEAD = 64'hDEAD_0000_0000_0000;
    localparam logic [63:0] K_AB   = 64'hAB00_0000_0000_0000;
    localparam logic [63:0] K_ABCD = 64'hABCD_0000_0000_0000;
    localparam logic [63:0] K_ABQ  = 64'hABCD_1234_0000_0000;
    localparam logic [63:0] K_777  = 64'h7770_0000_0000_0000;

    logic [63:0] fill_pfx [6] = '{64'h1110_0000_0000_0000, 64'h2220_0000_0000_0000,
                                  64'h3330_0000_0000_0000, 64'h4440_0000_0000_0000,
                                  64'h5550_0000_0000_0000, 64'h6660_0000_0000_0000};

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  c0;
        bit  ok;
        lk_exp_t  le0;
        upd_exp_t ue0;

        rst = 1'b0; upd_valid = 1'b0; lk_valid = 1'b0; upd_op = OP_INSERT;
        upd_prefix = '0; upd_len = '0; upd_face = '0; lk_prefix = '0;

        @(negedge clk);
        #1;
        check("reset upd_ready", 64'(upd_ready), 64'd0);
        check("reset lk_ready", 64'(lk_ready), 64'd0);
        @(negedge clk);
        check("reset count", 64'(count), 64'd0);
        check("reset lk_done", 64'(lk_done), 64'd0);
        rst = 1'b1;
        #1;
        check("post-reset upd_ready", 64'(upd_ready), 64'd1);
        check("post-reset lk_ready", 64'(lk_ready), 64'd1);

        // Empty table: miss reports the default face; then a default route.
        do_lk(K_DEAD, 1'b0, 0, 15);
        do_upd(OP_INSERT, 64'h0, 0, 2, ST_OK, 1);
        do_lk(K_DEAD, 1'b1, 0, 2);
        do_upd(OP_DELETE, 64'h0, 0, 0, ST_OK, 0);

        // Longest-prefix selection; the len-16 insert is stored masked.
        do_upd(OP_INSERT, K_AB, 8, 3, ST_OK, 1);
        do_upd(OP_INSERT, 64'hABCD_FFFF_FFFF_FFFF, 16, 5, ST_OK, 2);
        do_lk(K_ABQ, 1'b1, 16, 5);
        do_lk(64'hABFF_0000_0000_0000, 1'b1, 8, 3);
        do_lk(64'h1200_0000_0000_0000, 1'b0, 0, 15);

        // Duplicate replaces the face; illegal length is rejected.
        do_upd(OP_INSERT, K_AB, 8, 7, ST_REPLACED, 2);
        do_lk(64'hAB11_0000_0000_0000, 1'b1, 8, 7);
        do_upd(OP_INSERT, K_AB, 65, 4, ST_MISS, 2);

        // Fill to DEPTH, then overflow.
        for (int i = 0; i < 6; i++) do_upd(OP_INSERT, fill_pfx[i], 12, i + 1, ST_OK, i + 3);
        do_upd(OP_INSERT, K_777, 12, 8, ST_FULL, 8);

        // Delete and fall back to the shorter route; second delete misses.
        do_upd(OP_DELETE, K_ABCD, 16, 0, ST_OK, 7);
        do_lk(K_ABQ, 1'b1, 8, 7);
        do_upd(OP_DELETE, K_ABCD, 16, 0, ST_MISS, 7);

        // Simultaneous requests: update first, lookup right after its FIN.
        @(negedge clk);
        upd_valid = 1'b1; upd_op = OP_INSERT; upd_prefix = 64'h9990_0000_0000_0000;
        upd_len = LEN_W'(12); upd_face = FACE_W'(9);
        lk_valid = 1'b1; lk_prefix = 64'h9991_2345_6789_ABCD;
        #1;
        check("both: upd_ready", 64'(upd_ready), 64'd1);
        check("both: lk_ready", 64'(lk_ready), 64'd0);
        c0 = cyc;
        ue0.status = ST_OK; ue0.cnt = 8; ue0.acc = cyc; ue0.tag = tag_n++;
        upd_q.push_back(ue0);
        @(posedge clk);
        #1 upd_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (lk_ready) ok = 1'b1;
        end
        if (ok) begin
            check("both: lk accept cycle", 64'(cyc - c0), 64'(DEPTH + 2));
            le0.hit = 1'b1; le0.len = LEN_W'(12); le0.face = FACE_W'(9); le0.acc = cyc; le0.tag = tag_n++;
            lk_q.push_back(le0);
        end else begin
            fail_now("both: lookup never accepted");
        end
        @(posedge clk);
        #1 lk_valid = 1'b0;
        wait_done();
        do_upd(OP_INSERT, K_777, 12, 8, ST_FULL, 8);

        // Reset in mid-scan of a lookup: no done, table emptied.
        @(negedge clk);
        lk_valid = 1'b1; lk_prefix = K_ABQ;
        #1;
        check("abort lk_ready", 64'(lk_ready), 64'd1);
        @(posedge clk);
        #1 lk_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("busy upd_ready", 64'(upd_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("mid-reset upd_ready", 64'(upd_ready), 64'd0);
        check("mid-reset lk_ready", 64'(lk_ready), 64'd0);
        check("mid-reset count", 64'(count), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("after abort upd_ready", 64'(upd_ready), 64'd1);
        check("after abort lk_face", 64'(lk_face), 64'd0);
        check("after abort lk_hit", 64'(lk_hit), 64'd0);
        check("after abort upd_status", 64'(upd_status), 64'd0);
        repeat (12) @(negedge clk);
        check("after abort count", 64'(count), 64'd0);
        do_lk(K_ABQ, 1'b0, 0, 15);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
